multicycle_control: RTL and testbench

Main control FSM for the multi-cycle LEGv8 core. It sequences the shared ALU, memory, register file and PC across multiple cycles per instruction for ADD/SUB/AND/ORR, LDUR, STUR, CBZ and B. It drives the 2-bit ALUop consumed by the ALU control decoder, plus all datapath mux selects and write enables. Memory accesses use a ready handshake so variable-latency memory can stall the sequence.

---
 rtl/multicycle_control_pkg.sv | 55 +++++
 rtl/multicycle_control_opcode_class.sv | 31 +++
 rtl/multicycle_control.sv | 158 +++++++++++++++
 tb/tb_multicycle_control.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle LEGv8 main control FSM.
// Holds the state encoding, ALUop and ALU operand mux encodings,
// the opcode constants and prefixes of each supported instruction class,
// and the bit positions of the one-hot opcode class vector.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_CBZ_EXEC = 4'd8,
        S_B_EXEC   = 4'd9
    } state_t;

    // ALUop values consumed by the ALU control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_REG   = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_DIMM   = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    // Full 11-bit opcodes and the fixed prefixes of the branch classes
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  CBZ_PREFIX = 8'b10110100;
    localparam logic [5:0]  B_PREFIX   = 6'b000101;

    // Bit positions inside the one-hot class vector
    localparam int CLS_W   = 6;
    localparam int CLS_R   = 5;
    localparam int CLS_LD  = 4;
    localparam int CLS_ST  = 3;
    localparam int CLS_CBZ = 2;
    localparam int CLS_B   = 1;
    localparam int CLS_ILL = 0;

endpackage

// File: rtl/multicycle_control_opcode_class.sv
// Combinational opcode classifier for the LEGv8 multi-cycle core.
// Ports:
//   opcode   in  11  instruction bits [31:21]
//   op_class out 6   one-hot {R, LD, ST, CBZ, B, ILL}
module opcode_class
    import multicycle_control_pkg::*;
(
    input  logic [10:0]      opcode,
    output logic [CLS_W-1:0] op_class
);

    // Exactly one class bit is set; anything unrecognised is illegal.
    always_comb begin
        op_class = '0;
        if (opcode == OP_ADD || opcode == OP_SUB ||
            opcode == OP_AND || opcode == OP_ORR) begin
            op_class[CLS_R] = 1'b1;
        end else if (opcode == OP_LDUR) begin
            op_class[CLS_LD] = 1'b1;
        end else if (opcode == OP_STUR) begin
            op_class[CLS_ST] = 1'b1;
        end else if (opcode[10:3] == CBZ_PREFIX) begin
            op_class[CLS_CBZ] = 1'b1;
        end else if (opcode[10:5] == B_PREFIX) begin
            op_class[CLS_B] = 1'b1;
        end else begin
            op_class[CLS_ILL] = 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle LEGv8 core.
// Sequences the shared ALU, memory, register file and PC for ADD/SUB/AND/ORR,
// LDUR, STUR, CBZ and B; memory states wait on the MemReady handshake.
// Ports:
//   CLK, Reset (sync, active-high)   clock and reset
//   Opcode[10:0], Zero, MemReady     IR opcode field, ALU zero flag, memory done
//   ALUop, ALUSrcA, ALUSrcB          ALU control and operand selects (2 bits)
//   PCSource, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
//   RegWrite, MemtoReg, Reg2Loc      datapath enables and selects
//   InstrDone, Illegal               last-cycle pulse, illegal-opcode pulse
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic        CLK,
    input  logic        Reset,
    input  logic [10:0] Opcode,
    input  logic        Zero,
    input  logic        MemReady,
    output logic [1:0]  ALUop,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic        PCSource,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        MemtoReg,
    output logic        Reg2Loc,
    output logic        InstrDone,
    output logic        Illegal
);

    state_t           state;
    state_t           next_state;
    logic [CLS_W-1:0] op_class;

    // The conditional branch combines PCWriteCond with Zero in the datapath,
    // so the flag is deliberately not consumed here.
    logic unused_zero;
    assign unused_zero = Zero;

    opcode_class u_opcode_class (
        .opcode   (Opcode),
        .op_class (op_class)
    );

    // State register; Reset returns to FETCH from any state, even mid-stall.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and output decode. Outputs are forced low while Reset is
    // high so no fetch or write is attempted during reset. Memory states
    // only advance, and only pulse IRWrite/PCWrite/InstrDone, on MemReady.
    always_comb begin
        next_state  = state;
        ALUop       = ALUOP_ADD;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_REG;
        PCSource    = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        MemtoReg    = 1'b0;
        Reg2Loc     = 1'b0;
        InstrDone   = 1'b0;
        Illegal     = 1'b0;
        if (!Reset) begin
            case (state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    IRWrite = MemReady;
                    PCWrite = MemReady;
                    if (MemReady) next_state = S_DECODE;
                end
                S_DECODE: begin
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_BRANCH;
                    if (op_class[CLS_R])                       next_state = S_R_EXEC;
                    else if (op_class[CLS_LD] || op_class[CLS_ST]) next_state = S_MEM_ADDR;
                    else if (op_class[CLS_CBZ])                next_state = S_CBZ_EXEC;
                    else if (op_class[CLS_B])                  next_state = S_B_EXEC;
                    else begin
                        Illegal    = 1'b1;
                        next_state = S_FETCH;
                    end
                end
                S_MEM_ADDR: begin
                    ALUSrcA = SRCA_REG;
                    ALUSrcB = SRCB_DIMM;
                    Reg2Loc = op_class[CLS_ST];
                    if (op_class[CLS_LD])      next_state = S_MEM_RD;
                    else if (op_class[CLS_ST]) next_state = S_MEM_WR;
                    else                       next_state = S_FETCH;
                end
                S_MEM_RD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                    if (MemReady) next_state = S_MEM_WB;
                end
                S_MEM_WB: begin
                    RegWrite   = 1'b1;
                    MemtoReg   = 1'b1;
                    InstrDone  = 1'b1;
                    next_state = S_FETCH;
                end
                S_MEM_WR: begin
                    MemWrite  = 1'b1;
                    IorD      = 1'b1;
                    Reg2Loc   = 1'b1;
                    InstrDone = MemReady;
                    if (MemReady) next_state = S_FETCH;
                end
                S_R_EXEC: begin
                    ALUSrcA    = SRCA_REG;
                    ALUSrcB    = SRCB_REG;
                    ALUop      = ALUOP_RTYPE;
                    next_state = S_R_WB;
                end
                S_R_WB: begin
                    RegWrite   = 1'b1;
                    InstrDone  = 1'b1;
                    next_state = S_FETCH;
                end
                S_CBZ_EXEC: begin
                    ALUSrcA     = SRCA_REG;
                    ALUSrcB     = SRCB_REG;
                    Reg2Loc     = 1'b1;
                    ALUop       = ALUOP_PASSB;
                    PCWriteCond = 1'b1;
                    PCSource    = 1'b1;
                    InstrDone   = 1'b1;
                    next_state  = S_FETCH;
                end
                S_B_EXEC: begin
                    PCWrite    = 1'b1;
                    PCSource   = 1'b1;
                    InstrDone  = 1'b1;
                    next_state = S_FETCH;
                end
                default: next_state = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed instruction sequences
// with hand-computed expectations, then randomized opcodes, stalls and resets
// checked every cycle against a step-per-instruction reference model.
module tb_multicycle_control;

    localparam int C_R = 0, C_LD = 1, C_ST = 2, C_CBZ = 3, C_B = 4, C_ILL = 5;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic [10:0] Opcode = '0;
    logic        Zero = 1'b0;
    logic        MemReady = 1'b0;
    logic [1:0]  ALUop, ALUSrcA, ALUSrcB;
    logic        PCSource, PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
    logic        IRWrite, RegWrite, MemtoReg, Reg2Loc, InstrDone, Illegal;

    int errors = 0;
    int checks = 0;

    // Reference model: position within the current instruction and its class
    int step = 0;
    int cls  = C_ILL;

    // Observations captured by runInstr for the directed literal checks
    logic [1:0] obsAluop;
    logic       obsPcw, obsPcwc, obsPcs, obsR2lAddr;
    logic       doneR2l, doneM2r;
    int         rwEarly, stallReads;

    always #5 CLK = ~CLK;

    multicycle_control dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .Opcode      (Opcode),
        .Zero        (Zero),
        .MemReady    (MemReady),
        .ALUop       (ALUop),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .PCSource    (PCSource),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .RegWrite    (RegWrite),
        .MemtoReg    (MemtoReg),
        .Reg2Loc     (Reg2Loc),
        .InstrDone   (InstrDone),
        .Illegal     (Illegal)
    );

    function automatic logic [17:0] actVec();
        return {ALUop, ALUSrcA, ALUSrcB, PCSource, PCWrite, PCWriteCond, IorD,
                MemRead, MemWrite, IRWrite, RegWrite, MemtoReg, Reg2Loc,
                InstrDone, Illegal};
    endfunction

    function automatic int classify(input logic [10:0] opc);
        logic [7:0] hi8;
        logic [5:0] hi6;
        hi8 = opc[10:3];
        hi6 = opc[10:5];
        if (opc == 11'b10001011000 || opc == 11'b11001011000 ||
            opc == 11'b10001010000 || opc == 11'b10101010000) return C_R;
        if (opc == 11'b11111000010) return C_LD;
        if (opc == 11'b11111000000) return C_ST;
        if (hi8 == 8'b10110100)     return C_CBZ;
        if (hi6 == 6'b000101)       return C_B;
        return C_ILL;
    endfunction

    // Expected outputs for a given instruction class, step and inputs.
    // Step 0 is the fetch, step 1 the decode; later steps depend on the class.
    function automatic logic [17:0] modelOutputs(input int c, input int s,
                                                 input logic mr, input logic rst);
        logic [1:0] aop, sa, sb;
        logic pcs, pcw, pcwc, iord, mrd, mwr, irw, rw, m2r, r2l, done, ill;
        {aop, sa, sb} = '0;
        {pcs, pcw, pcwc, iord, mrd, mwr, irw, rw, m2r, r2l, done, ill} = '0;
        if (!rst) begin
            if (s == 0) begin
                mrd = 1'b1; sb = 2'b01; irw = mr; pcw = mr;
            end else if (s == 1) begin
                sa = 2'b10; sb = 2'b11; ill = (c == C_ILL);
            end else if (s == 2) begin
                case (c)
                    C_R:   begin sa = 2'b01; aop = 2'b10; end
                    C_LD:  begin sa = 2'b01; sb = 2'b10; end
                    C_ST:  begin sa = 2'b01; sb = 2'b10; r2l = 1'b1; end
                    C_CBZ: begin sa = 2'b01; r2l = 1'b1; aop = 2'b01;
                                 pcwc = 1'b1; pcs = 1'b1; done = 1'b1; end
                    C_B:   begin pcw = 1'b1; pcs = 1'b1; done = 1'b1; end
                    default: ;
                endcase
            end else if (s == 3) begin
                case (c)
                    C_R:  begin rw = 1'b1; done = 1'b1; end
                    C_LD: begin mrd = 1'b1; iord = 1'b1; end
                    C_ST: begin mwr = 1'b1; iord = 1'b1; r2l = 1'b1; done = mr; end
                    default: ;
                endcase
            end else if (s == 4) begin
                rw = 1'b1; m2r = 1'b1; done = 1'b1;
            end
        end
        return {aop, sa, sb, pcs, pcw, pcwc, iord, mrd, mwr, irw, rw, m2r, r2l, done, ill};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [10:0] opc, input logic mr);
        @(negedge CLK);
        Reset    = rst;
        Opcode   = opc;
        MemReady = mr;
        Zero     = 1'($urandom_range(0, 1));
    endtask

    // Compares the DUT against the model for this cycle, then moves the
    // model to the step it must be in after the coming rising edge.
    task automatic checkOutput(input string name);
        #2;
        if (step == 1) cls = classify(Opcode);
        check(name, 32'(actVec()), 32'(modelOutputs(cls, step, MemReady, Reset)));
        if (Reset) begin
            step = 0;
        end else begin
            case (step)
                0: if (MemReady) step = 1;
                1: step = (cls == C_ILL) ? 0 : 2;
                2: step = (cls == C_CBZ || cls == C_B) ? 0 : 3;
                3: begin
                    if (cls == C_R)                   step = 0;
                    else if (cls == C_LD && MemReady) step = 4;
                    else if (cls == C_ST && MemReady) step = 0;
                end
                default: step = 0;
            endcase
        end
    endtask

    // Runs one instruction from fetch to InstrDone, holding MemReady low for
    // 'stalls' cycles in the memory-access step, and checks the cycle count.
    task automatic runInstr(input string name, input logic [10:0] opc,
                            input int stalls, input int expCycles);
        int n = 0;
        int stallLeft = stalls;
        bit done = 0;
        logic mr;
        int s;
        rwEarly = 0;
        stallReads = 0;
        while (!done && n < 30) begin
            s  = step;
            mr = 1'b1;
            if (s == 3 && (cls == C_LD || cls == C_ST) && stallLeft > 0) begin
                mr = 1'b0;
                stallLeft--;
            end
            applyStimulus(1'b0, opc, mr);
            checkOutput(name);
            n++;
            if (s == 2) begin
                obsAluop = ALUop; obsPcw = PCWrite; obsPcwc = PCWriteCond;
                obsPcs = PCSource; obsR2lAddr = Reg2Loc;
            end
            if (!mr && MemRead) stallReads++;
            if (RegWrite && !InstrDone) rwEarly++;
            if (InstrDone) begin
                done = 1;
                doneR2l = Reg2Loc;
                doneM2r = MemtoReg;
            end
        end
        check({name, " cycles"}, 32'(n), 32'(expCycles));
    endtask

    initial begin : main
        logic [10:0] opc;
        int          pick;
        logic        rst, mr;

        // Reset state
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 11'($urandom), 1'b1);
            checkOutput("reset");
            check("reset outputs zero", 32'(actVec()), 32'd0);
        end

        runInstr("add", 11'b10001011000, 0, 4);
        check("add ALUop in exec", 32'(obsAluop), 32'd2);

        runInstr("ldur stall", 11'b11111000010, 3, 8);
        check("ldur early RegWrite", 32'(rwEarly), 32'd0);
        check("ldur MemRead held", 32'(stallReads), 32'd3);
        check("ldur MemtoReg at wb", 32'(doneM2r), 32'd1);

        runInstr("cbz", 11'b10110100101, 0, 3);
        check("cbz ALUop", 32'(obsAluop), 32'd1);
        check("cbz PCWriteCond", 32'(obsPcwc), 32'd1);
        check("cbz PCWrite", 32'(obsPcw), 32'd0);

        runInstr("b", 11'b00010110011, 0, 3);
        check("b PCWrite", 32'(obsPcw), 32'd1);
        check("b PCSource", 32'(obsPcs), 32'd1);

        runInstr("stur", 11'b11111000000, 0, 4);
        check("stur Reg2Loc addr", 32'(obsR2lAddr), 32'd1);
        check("stur Reg2Loc wr", 32'(doneR2l), 32'd1);

        // Illegal opcode: pulse in decode, then straight back to fetch
        applyStimulus(1'b0, 11'b11111111111, 1'b1);
        checkOutput("illegal fetch");
        applyStimulus(1'b0, 11'b11111111111, 1'b1);
        checkOutput("illegal decode");
        check("illegal pulse", 32'(Illegal), 32'd1);
        check("illegal no done", 32'({InstrDone, RegWrite, MemWrite}), 32'd0);
        applyStimulus(1'b0, 11'b11111111111, 1'b1);
        checkOutput("illegal refetch");
        check("illegal refetch MemRead", 32'(MemRead), 32'd1);

        // Reset in the middle of a stalled store
        applyStimulus(1'b1, 11'b11111000000, 1'b0);
        checkOutput("realign reset");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 11'b11111000000, 1'b1);
            checkOutput("st to mem_wr");
        end
        applyStimulus(1'b0, 11'b11111000000, 1'b0);
        checkOutput("st stalled");
        check("st stalled no done", 32'(InstrDone), 32'd0);
        applyStimulus(1'b1, 11'b11111000000, 1'b0);
        checkOutput("reset mid stall");
        check("reset mid stall zero", 32'(actVec()), 32'd0);
        applyStimulus(1'b1, 11'b11111000000, 1'b1);
        checkOutput("reset hold");
        check("reset hold MemRead", 32'(MemRead), 32'd0);
        applyStimulus(1'b0, 11'b11111000000, 1'b1);
        checkOutput("fetch after reset");
        check("fetch after reset MemRead", 32'(MemRead), 32'd1);
        check("fetch after reset MemWrite", 32'(MemWrite), 32'd0);

        // Randomized phase; the opcode only changes while fetching
        opc = 11'b11111000000;
        for (int i = 0; i < 600; i++) begin
            if (step == 0) begin
                pick = $urandom_range(0, 5);
                case (pick)
                    0: begin
                        case ($urandom_range(0, 3))
                            0: opc = 11'b10001011000;
                            1: opc = 11'b11001011000;
                            2: opc = 11'b10001010000;
                            default: opc = 11'b10101010000;
                        endcase
                    end
                    1: opc = 11'b11111000010;
                    2: opc = 11'b11111000000;
                    3: opc = {8'b10110100, 3'($urandom)};
                    4: opc = {6'b000101, 5'($urandom)};
                    default: opc = 11'($urandom);
                endcase
            end
            rst = ($urandom_range(0, 39) == 0);
            mr  = ($urandom_range(0, 2) != 0);
            applyStimulus(rst, opc, mr);
            checkOutput("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
